// File: rtl/regfile_arb_pkg.sv
// Shared constants for the register-file write arbiter and its round-robin core.
package regfile_arb_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_DATA_WIDTH = 64;
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = 5'd0;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just after pointer and wraps.
module rr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [N-1:0] above_mask;
  logic [N-1:0] masked_req;
  logic [N-1:0] pick;

  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign above_mask[gi] = (IW'(gi) > pointer);
  end

  // Requests above the pointer go first; otherwise wrap to the lowest index.
  assign masked_req = req & above_mask;
  assign pick       = (|masked_req) ? masked_req : req;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pick[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback sources with a
// one-cycle staged write that doubles as a forwarding tap.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          reg_write,
  output logic [ADDR_WIDTH-1:0]         rd_address,
  output logic [DATA_WIDTH-1:0]         write_data,
  output logic                          fwd_valid,
  output logic [ADDR_WIDTH-1:0]         fwd_address,
  output logic [DATA_WIDTH-1:0]         fwd_data,
  output logic [CNT_WIDTH-1:0]          conflict_count
);

  localparam int PW = idx_width(NUM_REQ);

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [PW-1:0]         pointer_reg;
  logic [NUM_REQ-1:0]    grant;
  logic [PW-1:0]         grant_idx;
  logic                  transfer;
  logic                  conflict;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req       (req_valid),
    .pointer   (pointer_reg),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = reset_n ? grant : '0;
  assign transfer  = |(req_valid & req_ready);
  assign sel_addr  = addr_arr[grant_idx];
  assign sel_data  = data_arr[grant_idx];
  assign conflict  = $countones(req_valid) > $countones(req_valid & req_ready);

  // Reset value makes requester 0 the first winner.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pointer_reg <= PW'(NUM_REQ - 1);
    end else if (transfer) begin
      pointer_reg <= grant_idx;
    end
  end

  logic                  reg_write_reg;
  logic [ADDR_WIDTH-1:0] rd_address_reg;
  logic [DATA_WIDTH-1:0] write_data_reg;

  // Writes to x0 still consume the slot but never raise the write enable.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      reg_write_reg  <= 1'b0;
      rd_address_reg <= '0;
      write_data_reg <= '0;
    end else if (transfer) begin
      reg_write_reg  <= (sel_addr != ADDR_WIDTH'(ZERO_REG));
      rd_address_reg <= sel_addr;
      write_data_reg <= sel_data;
    end else begin
      reg_write_reg  <= 1'b0;
    end
  end

  logic [CNT_WIDTH-1:0] count_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (conflict && (count_reg != '1)) begin
      count_reg <= count_reg + CNT_WIDTH'(1);
    end
  end

  assign reg_write      = reg_write_reg;
  assign rd_address     = rd_address_reg;
  assign write_data     = write_data_reg;
  assign fwd_valid      = reg_write_reg;
  assign fwd_address    = rd_address_reg;
  assign fwd_data       = write_data_reg;
  assign conflict_count = count_reg;

endmodule
